sqr_wave_meas: RTL and testbench
================================

SQR_WAVE_MEAS -- requirements
Module: sqr_wave_meas

Interface
REQ-001 SHALL have parameter DT_W, default 8, sample width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the sample counters.
REQ-003 SHALL have parameter HYST, default 4, hysteresis half-width in LSBs.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  measurement enable.
REQ-007 sample_in  input  DT_W  unsigned ADC sample, e.g. square-generator output.
REQ-008 sample_valid  input  1  sample_in qualifier.
REQ-009 thr  input  DT_W  slicing threshold.
REQ-010 high_cnt  output  CNT_W  high-phase length of last period, in samples.
REQ-011 low_cnt  output  CNT_W  low-phase length of last period, in samples.
REQ-012 period_cnt  output  CNT_W+1  high_cnt+low_cnt, no truncation.
REQ-013 vmax  output  DT_W  maximum sample in last period.
REQ-014 vmin  output  DT_W  minimum sample in last period.
REQ-015 meas_valid  output  1  one-cycle pulse when results update.
REQ-016 timeout  output  1  one-cycle pulse on counter saturation.

Function
REQ-017 SHALL process only cycles with sample_valid=1; other cycles change no counter, level or state.
REQ-018 Slicer SHALL set level=1 when sample_in >= thr+HYST (clamped to 2^DT_W-1), level=0 when sample_in <= thr-HYST (clamped to 0), else hold level.
REQ-019 FSM states SHALL be SEEK, ARM, HIGH, LOW.
REQ-020 SEEK: on level=0 -> ARM; ARM: on level 0->1 -> HIGH; HIGH: on level 1->0 -> LOW; LOW: on level 0->1 -> publish, -> HIGH.
REQ-021 The sample causing a level transition SHALL count in the new phase; high_cnt/low_cnt count samples in HIGH/LOW.
REQ-022 vmax/vmin trackers SHALL restart at the sample entering HIGH and include every valid sample through the last LOW sample.
REQ-023 Publish SHALL register high_cnt, low_cnt, period_cnt, vmax, vmin and pulse meas_valid in the cycle after the closing rising-edge sample; that sample starts the next HIGH count at 1.
REQ-024 A HIGH or LOW counter reaching 2^CNT_W-1 SHALL pulse timeout one cycle later, clear counters, go to SEEK, and not pulse meas_valid.
REQ-025 enable=0 SHALL synchronously force SEEK and clear counters/trackers; result outputs hold last values; enable=0 wins over a simultaneous edge.
REQ-026 meas_valid and timeout SHALL never both be 1.

Reset
REQ-027 rst_n low SHALL clear all outputs to 0, FSM to SEEK, level to 0, counters and trackers to 0, immediately.
REQ-028 After reset release the first meas_valid SHALL require a full low->high->low->high sequence.

Configuration
REQ-029 Macro SQR_MEAS_AUTO_THRESH_EN defined: effective threshold = (vmax+vmin)>>1 of last published result once at least one meas_valid has occurred, thr before that and after reset.
REQ-030 SQR_MEAS_AUTO_THRESH_EN undefined: effective threshold is always thr; no extra state.

Structure
REQ-031 Shared package sqr_wave_pkg SHALL hold FSM state encoding and default DT_W/CNT_W constants.
REQ-032 Hysteresis comparator SHALL be sub-module sqr_level_slicer (sample, threshold, HYST -> level).

Verification
REQ-033 thr=128, repeating 10x200 then 10x55, valid every cycle -> high_cnt=10, low_cnt=10, period_cnt=20, vmax=200, vmin=55 each period.
REQ-034 3x255 then 17x0 -> high_cnt=3, low_cnt=17, period_cnt=20.
REQ-035 Single sample 130 inside a low phase of 55 with thr=128 -> ignored, low_cnt unchanged.
REQ-036 Constant 200 for 65535 valid samples, CNT_W=16 -> one timeout pulse, no meas_valid, FSM in SEEK.
REQ-037 sample_valid toggled every other cycle with 33 pattern -> same counts as REQ-033.
REQ-038 rst_n asserted mid-HIGH -> all outputs 0 at once; next meas_valid only after a full new period.

Source files
------------

// File: rtl/sqr_wave_pkg.sv
// Shared FSM encoding and default widths for the square-wave measurement block.
package sqr_wave_pkg;

  localparam int DEF_DT_W  = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } meas_state_e;

endpackage

// File: rtl/sqr_level_slicer.sv
// Hysteresis comparator: resolves a sample into a logic level around a threshold,
// holding the previous level while the sample sits inside the dead band.
module sqr_level_slicer #(
  parameter int DT_W = 8,
  parameter int HYST = 4
) (
  input  logic [DT_W-1:0] sample_i,
  input  logic [DT_W-1:0] thr_i,
  input  logic            level_i,
  output logic            level_o
);

  localparam logic [DT_W:0]   HYST_X = (DT_W+1)'(HYST);
  localparam logic [DT_W-1:0] HYST_N = DT_W'(HYST);
  localparam logic [DT_W:0]   FULL_X = {1'b0, {DT_W{1'b1}}};

  logic [DT_W:0]   sum_x;
  logic [DT_W-1:0] hi_thr;
  logic [DT_W-1:0] lo_thr;

  // Band edges saturate at the sample range rather than wrapping.
  assign sum_x  = {1'b0, thr_i} + HYST_X;
  assign hi_thr = (sum_x > FULL_X) ? {DT_W{1'b1}} : sum_x[DT_W-1:0];
  assign lo_thr = ({1'b0, thr_i} >= HYST_X) ? (thr_i - HYST_N) : '0;

  assign level_o = (sample_i >= hi_thr) ? 1'b1 :
                   (sample_i <= lo_thr) ? 1'b0 : level_i;

endmodule

// File: rtl/sqr_wave_meas.sv
// Square-wave meter: high/low phase lengths, period and min/max amplitude per period.
// Define SQR_MEAS_AUTO_THRESH_EN to slice at the midpoint of the last published vmax/vmin.
module sqr_wave_meas
  import sqr_wave_pkg::*;
#(
  parameter int DT_W  = DEF_DT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int HYST  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DT_W-1:0]  sample_in,
  input  logic             sample_valid,
  input  logic [DT_W-1:0]  thr,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period_cnt,
  output logic [DT_W-1:0]  vmax,
  output logic [DT_W-1:0]  vmin,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

  meas_state_e      state_q, state_d;
  logic             level_q, slice_lvl;
  logic             rise, fall, publish, sat_hit;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [DT_W-1:0]  tmax_q, tmax_d, tmin_q, tmin_d;
  logic [DT_W-1:0]  eff_thr;

  logic [CNT_W-1:0] high_cnt_q, low_cnt_q;
  logic [CNT_W:0]   period_q;
  logic [DT_W-1:0]  vmax_q, vmin_q;
  logic             meas_valid_q, timeout_q;

  sqr_level_slicer #(
    .DT_W (DT_W),
    .HYST (HYST)
  ) u_slicer (
    .sample_i (sample_in),
    .thr_i    (eff_thr),
    .level_i  (level_q),
    .level_o  (slice_lvl)
  );

`ifdef SQR_MEAS_AUTO_THRESH_EN
  logic have_res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       have_res_q <= 1'b0;
    else if (publish) have_res_q <= 1'b1;
  end

  assign eff_thr = have_res_q ? DT_W'(({1'b0, vmax_q} + {1'b0, vmin_q}) >> 1) : thr;
`else
  assign eff_thr = thr;
`endif

  assign rise    = sample_valid & ~level_q & slice_lvl;
  assign fall    = sample_valid & level_q & ~slice_lvl;
  assign publish = enable & (state_q == ST_LOW) & rise;
  // Saturation is taken on the sample that would bring a phase counter to all-ones.
  assign sat_hit = enable & sample_valid &
                   (((state_q == ST_HIGH) & ~fall & (hcnt_q == CNT_LAST)) |
                    ((state_q == ST_LOW)  & ~rise & (lcnt_q == CNT_LAST)));

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    if (!enable || sat_hit) begin
      state_d = ST_SEEK;
    end else if (sample_valid) begin
      case (state_q)
        ST_SEEK: if (!slice_lvl) state_d = ST_ARM;
        ST_ARM:  if (rise)       state_d = ST_HIGH;
        ST_HIGH: if (fall)       state_d = ST_LOW;
        ST_LOW:  if (rise)       state_d = ST_HIGH;
        default:                 state_d = ST_SEEK;
      endcase
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    lcnt_d = lcnt_q;
    tmax_d = tmax_q;
    tmin_d = tmin_q;
    if (!enable || sat_hit) begin
      hcnt_d = '0;
      lcnt_d = '0;
      tmax_d = '0;
      tmin_d = '0;
    end else if (sample_valid && state_q != ST_SEEK) begin
      if (rise) begin
        // The rising sample opens a fresh HIGH phase and restarts the trackers.
        hcnt_d = CNT_ONE;
        lcnt_d = '0;
        tmax_d = sample_in;
        tmin_d = sample_in;
      end else if (state_q != ST_ARM) begin
        if (fall || state_q == ST_LOW) lcnt_d = lcnt_q + CNT_ONE;
        else                           hcnt_d = hcnt_q + CNT_ONE;
        tmax_d = (sample_in > tmax_q) ? sample_in : tmax_q;
        tmin_d = (sample_in < tmin_q) ? sample_in : tmin_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEEK;
      level_q      <= 1'b0;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      tmax_q       <= '0;
      tmin_q       <= '0;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      period_q     <= '0;
      vmax_q       <= '0;
      vmin_q       <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      tmax_q       <= tmax_d;
      tmin_q       <= tmin_d;
      meas_valid_q <= publish;
      timeout_q    <= sat_hit;
      if (sample_valid) level_q <= slice_lvl;
      if (publish) begin
        high_cnt_q <= hcnt_q;
        low_cnt_q  <= lcnt_q;
        period_q   <= {1'b0, hcnt_q} + {1'b0, lcnt_q};
        vmax_q     <= tmax_q;
        vmin_q     <= tmin_q;
      end
    end
  end

  assign high_cnt   = high_cnt_q;
  assign low_cnt    = low_cnt_q;
  assign period_cnt = period_q;
  assign vmax       = vmax_q;
  assign vmin       = vmin_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_sqr_wave_meas.sv
// Self-checking bench for sqr_wave_meas against a segment-based reference model.
module tb_sqr_wave_meas;

  localparam int DT_W  = 8;
  localparam int CNT_W = 16;
  localparam int HYST  = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int SMAX  = (1 << DT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic             sample_valid;
  logic [DT_W-1:0]  sample_in;
  logic [DT_W-1:0]  thr;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic [CNT_W:0]   period_cnt;
  logic [DT_W-1:0]  vmax, vmin;
  logic             meas_valid, timeout;

  typedef struct packed {
    logic             mv;
    logic             to;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] lc;
    logic [CNT_W:0]   pc;
    logic [DT_W-1:0]  mx;
    logic [DT_W-1:0]  mn;
  } obs_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: armed = a low level has been seen, open = a period is being collected.
  bit   m_level, m_armed, m_open, m_have;
  int   m_nh, m_nl, m_max, m_min;
  obs_t m_res;

  sqr_wave_meas #(
    .DT_W  (DT_W),
    .CNT_W (CNT_W),
    .HYST  (HYST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .thr          (thr),
    .high_cnt     (high_cnt),
    .low_cnt      (low_cnt),
    .period_cnt   (period_cnt),
    .vmax         (vmax),
    .vmin         (vmin),
    .meas_valid   (meas_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic obs_t dut_obs();
    obs_t o;
    o.mv = meas_valid;
    o.to = timeout;
    o.hc = high_cnt;
    o.lc = low_cnt;
    o.pc = period_cnt;
    o.mx = vmax;
    o.mn = vmin;
    return o;
  endfunction

  function automatic logic [DT_W-1:0] sq(int k, int nh, int nl,
                                         logic [DT_W-1:0] vh, logic [DT_W-1:0] vl);
    return ((k % (nh + nl)) < nh) ? vh : vl;
  endfunction

  task automatic model_reset();
    m_level = 1'b0; m_armed = 1'b0; m_open = 1'b0; m_have = 1'b0;
    m_nh = 0; m_nl = 0; m_max = 0; m_min = 0;
    m_res = '0;
  endtask

  task automatic model_step(input bit v, input int s);
    int t, hi, lo;
    bit nl, rise;
    m_res.mv = 1'b0;
    m_res.to = 1'b0;
    t = int'(thr);
`ifdef SQR_MEAS_AUTO_THRESH_EN
    if (m_have) t = (int'(m_res.mx) + int'(m_res.mn)) / 2;
`endif
    nl = m_level;
    if (v) begin
      hi = (t + HYST > SMAX) ? SMAX : t + HYST;
      lo = (t - HYST < 0) ? 0 : t - HYST;
      if (s >= hi)      nl = 1'b1;
      else if (s <= lo) nl = 1'b0;
    end
    rise    = nl && !m_level;
    m_level = nl;
    if (!enable) begin
      m_armed = 1'b0;
      m_open  = 1'b0;
      return;
    end
    if (!v) return;
    if (!m_armed) begin
      if (!nl) m_armed = 1'b1;
    end else if (!m_open) begin
      if (rise) begin
        m_open = 1'b1; m_nh = 1; m_nl = 0; m_max = s; m_min = s;
      end
    end else if (rise) begin
      m_res.mv = 1'b1;
      m_res.hc = CNT_W'(m_nh);
      m_res.lc = CNT_W'(m_nl);
      m_res.pc = (CNT_W+1)'(m_nh + m_nl);
      m_res.mx = DT_W'(m_max);
      m_res.mn = DT_W'(m_min);
      m_have   = 1'b1;
      m_nh = 1; m_nl = 0; m_max = s; m_min = s;
    end else begin
      if (nl) m_nh++;
      else    m_nl++;
      if (s > m_max) m_max = s;
      if (s < m_min) m_min = s;
      if ((m_nl == 0 && m_nh == CMAX) || m_nl == CMAX) begin
        m_res.to = 1'b1;
        m_armed  = 1'b0;
        m_open   = 1'b0;
      end
    end
  endtask

  task automatic step(input bit v, input logic [DT_W-1:0] s, output obs_t got, output obs_t exp);
    @(negedge clk);
    sample_valid = v;
    sample_in    = s;
    model_step(v, int'(s));
    @(posedge clk);
    #1;
    got = dut_obs();
    exp = m_res;
  endtask

  task automatic quiesce();
    obs_t g, e;
    enable = 1'b0;
    step(1'b0, '0, g, e);
    enable = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got, exp;
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = '0; thr = 8'd128;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    got = dut_obs();
    n_checks++;
    if (got !== '0) begin
      n_errors++; $display("FAIL reset_outputs got=%h exp=0", got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'(k), got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL reset_idle k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_square_33();
    obs_t got, exp;
    int pulses = 0;
    thr = 8'd128;
    quiesce();
    for (int k = 0; k < 100; k++) begin
      step(1'b1, sq(k, 10, 10, 8'd200, 8'd55), got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL square_33 k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.mv) begin
        pulses++;
        n_checks++;
        if ({got.hc, got.lc, got.pc, got.mx, got.mn} !== {16'd10, 16'd10, 17'd20, 8'd200, 8'd55}) begin
          n_errors++; $display("FAIL square_33_values got=%h required hc=10 lc=10 pc=20 mx=200 mn=55", got);
        end
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_errors++; $display("FAIL square_33_pulses got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_duty_34();
    obs_t got, exp;
    int pulses = 0;
    thr = 8'd128;
    quiesce();
    for (int k = 0; k < 100; k++) begin
      step(1'b1, sq(k, 3, 17, 8'd255, 8'd0), got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL duty_34 k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.mv) begin
        pulses++;
        n_checks++;
        if ({got.hc, got.lc, got.pc, got.mx, got.mn} !== {16'd3, 16'd17, 17'd20, 8'd255, 8'd0}) begin
          n_errors++; $display("FAIL duty_34_values got=%h required hc=3 lc=17 pc=20", got);
        end
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_errors++; $display("FAIL duty_34_pulses got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_glitch_35();
    obs_t got, exp;
    int pulses = 0;
    logic [DT_W-1:0] s;
    thr = 8'd128;
    quiesce();
    for (int k = 0; k < 100; k++) begin
      s = sq(k, 10, 10, 8'd200, 8'd55);
      if (k % 20 == 14) s = 8'd130;
      step(1'b1, s, got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL glitch_35 k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.mv) begin
        pulses++;
        n_checks++;
        if ({got.hc, got.lc, got.pc} !== {16'd10, 16'd10, 17'd20}) begin
          n_errors++; $display("FAIL glitch_35_values got=%h required hc=10 lc=10 pc=20", got);
        end
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_errors++; $display("FAIL glitch_35_pulses got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_sparse_37();
    obs_t got, exp;
    int pulses = 0;
    thr = 8'd128;
    quiesce();
    for (int k = 0; k < 200; k++) begin
      if (k % 2 == 0) step(1'b1, sq(k / 2, 10, 10, 8'd200, 8'd55), got, exp);
      else            step(1'b0, 8'($urandom_range(SMAX, 0)), got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL sparse_37 k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.mv) begin
        pulses++;
        n_checks++;
        if ({got.hc, got.lc, got.pc, got.mx, got.mn} !== {16'd10, 16'd10, 17'd20, 8'd200, 8'd55}) begin
          n_errors++; $display("FAIL sparse_37_values got=%h required hc=10 lc=10 pc=20 mx=200 mn=55", got);
        end
      end
    end
    n_checks++;
    if (pulses != 3) begin
      n_errors++; $display("FAIL sparse_37_pulses got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_enable();
    obs_t got, exp;
    int pulses = 0;
    thr = 8'd128;
    quiesce();
    for (int k = 0; k < 65; k++) begin
      step(1'b1, sq(k, 10, 10, 8'd200, 8'd55), got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL enable_pre k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ($urandom_range(1, 0) != 0) ? 8'd200 : 8'd55, got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL enable_off k=%0d got=%h exp=%h", k, got, exp);
      end
      n_checks++;
      if ({got.mv, got.to, got.hc, got.lc, got.pc, got.mx, got.mn} !==
          {2'b00, 16'd10, 16'd10, 17'd20, 8'd200, 8'd55}) begin
        n_errors++; $display("FAIL enable_hold k=%0d got=%h required held 10/10/20/200/55", k, got);
      end
    end
    enable = 1'b1;
    for (int k = 0; k < 31; k++) begin
      step(1'b1, (k < 10 || (k >= 20 && k < 30)) ? 8'd55 : 8'd200, got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL enable_rearm k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.mv) pulses++;
    end
    n_checks++;
    if (pulses != 1 || got.mv !== 1'b1 || got.hc !== 16'd10 || got.lc !== 16'd10) begin
      n_errors++; $display("FAIL enable_rearm_result pulses=%0d last=%h required one pulse at end with 10/10", pulses, got);
    end
  endtask

  task automatic test_rst_mid_38();
    obs_t got, exp;
    int pulses = 0;
    int first_idx = -1;
    thr = 8'd128;
    quiesce();
    for (int k = 0; k < 45; k++) begin
      step(1'b1, sq(k, 10, 10, 8'd200, 8'd55), got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL rst_mid_pre k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    got = dut_obs();
    n_checks++;
    if (got !== '0) begin
      n_errors++; $display("FAIL rst_mid_async got=%h exp=0", got);
    end
    model_reset();
    sample_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      step(1'b1, sq(k, 10, 10, 8'd200, 8'd55), got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL rst_mid_post k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.mv) begin
        pulses++;
        if (first_idx < 0) first_idx = k;
      end
    end
    n_checks++;
    if (pulses != 2 || first_idx != 40) begin
      n_errors++; $display("FAIL rst_mid_first pulses=%0d first=%0d required pulses=2 first=40", pulses, first_idx);
    end
  endtask

  task automatic test_random();
    obs_t got, exp;
    int pulses = 0;
    int t, nh, nl;
    bit v;
    logic [DT_W-1:0] s;
    t   = int'($urandom_range(190, 60));
    thr = DT_W'(t);
    quiesce();
    for (int p = 0; p < 40; p++) begin
      nh = int'($urandom_range(12, 1));
      nl = int'($urandom_range(12, 1));
      for (int i = 0; i < nh + nl; i++) begin
        v = ($urandom_range(3, 0) != 0);
        if ($urandom_range(9, 0) == 0)
          s = DT_W'($urandom_range(t + HYST - 1, t - HYST + 1));
        else if (i < nh)
          s = DT_W'($urandom_range(SMAX, t + HYST));
        else
          s = DT_W'($urandom_range(t - HYST, 0));
        enable = ($urandom_range(59, 0) != 0);
        step(v, s, got, exp);
        n_checks++;
        if (got !== exp) begin
          n_errors++; $display("FAIL random p=%0d i=%0d got=%h exp=%h", p, i, got, exp);
        end
        if (got.mv) pulses++;
      end
    end
    enable = 1'b1;
    n_checks++;
    if (pulses == 0) begin
      n_errors++; $display("FAIL random_pulses got=0 required at least 1");
    end
  endtask

  task automatic test_timeout_36();
    obs_t got, exp;
    int tos = 0;
    int mvs = 0;
    int to_idx = -1;
    thr = 8'd128;
    quiesce();
    for (int k = 0; k < 3 + CMAX + 10; k++) begin
      step(1'b1, (k < 3) ? 8'd55 : 8'd200, got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL timeout_36 k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.to) begin
        tos++;
        to_idx = k;
      end
      if (got.mv) mvs++;
    end
    n_checks++;
    if (tos != 1 || mvs != 0 || to_idx != 3 + CMAX - 1) begin
      n_errors++; $display("FAIL timeout_36_pulse timeouts=%0d meas=%0d at=%0d required 1/0/%0d", tos, mvs, to_idx, 3 + CMAX - 1);
    end
    for (int k = 0; k < 31; k++) begin
      step(1'b1, (k < 10 || (k >= 20 && k < 30)) ? 8'd55 : 8'd200, got, exp);
      n_checks++;
      if (got !== exp) begin
        n_errors++; $display("FAIL timeout_recover k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    n_checks++;
    if (got.mv !== 1'b1 || got.hc !== 16'd10 || got.lc !== 16'd10 || got.pc !== 17'd20) begin
      n_errors++; $display("FAIL timeout_recover_result got=%h required mv=1 hc=10 lc=10 pc=20", got);
    end
  endtask

  initial begin
    test_reset();
    test_square_33();
    test_duty_34();
    test_glitch_35();
    test_sparse_37();
    test_enable();
    test_rst_mid_38();
    test_random();
    test_timeout_36();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
